bin2bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, processing one input bit per clock. It is the next generation of the team's combinational 4-bit binary-to-BCD encoder, generalised to any input width and digit count. It adds a start/busy/valid handshake, clock-enable stalling and overflow detection. It sits between binary datapaths (counters, ALU results) and seven-segment display drivers.

---
 rtl/bin2bcd_seq.sv | 74 +++++++
 tb/tb_bin2bcd_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle shift-add-3 binary to BCD converter with start/valid handshake
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  overflow
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state, state_nx;
  logic [BIN_W-1:0]  sh, sh_nx;
  logic [BW-1:0]     scr, scr_nx, adj;
  logic              ovf, ovf_nx, done;
  logic [CW-1:0]     cnt, cnt_nx;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (scr[4*g +: 4] >= 4'd5) ? scr[4*g +: 4] + 4'd3 : scr[4*g +: 4];
  end
  assign busy  = (state == SHIFT);
  assign ready = !busy;
  // next state: load on accepted start, one correct-and-shift iteration per enabled cycle
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    scr_nx   = scr;
    ovf_nx   = ovf;
    cnt_nx   = cnt;
    done     = 1'b0;
    if (EN && state == IDLE && start) begin
      sh_nx    = bin;
      scr_nx   = '0;
      ovf_nx   = 1'b0;
      cnt_nx   = CW'(BIN_W);
      state_nx = SHIFT;
    end else if (EN && state == SHIFT) begin
      {scr_nx, sh_nx} = {adj[BW-2:0], sh, 1'b0};
      ovf_nx   = ovf | adj[BW-1];
      cnt_nx   = cnt - CW'(1);
      done     = (cnt == CW'(1));
      state_nx = done ? IDLE : SHIFT;
    end
  end
  // state and result registers; valid pulses only on the enabled completion edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      scr      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      sh       <= sh_nx;
      scr      <= scr_nx;
      ovf      <= ovf_nx;
      cnt      <= cnt_nx;
      bcd      <= done ? scr_nx : bcd;
      overflow <= done ? ovf_nx : overflow;
      valid    <= done;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq at 3 and 2 digits against a decimal model
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0;
  logic [7:0] bin = '0;
  logic rdy3, busy3, val3, ovf3, rdy2, busy2, val2, ovf2;
  logic [11:0] bcd3;
  logic [7:0] bcd2;
  int total = 0, bad = 0, en_edges = 0;
  typedef struct { int v; int e0; } exp_t;
  exp_t q3[$], q2[$];

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .EN(en), .start(start), .bin(bin),
    .ready(rdy3), .busy(busy3), .bcd(bcd3), .valid(val3), .overflow(ovf3));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .EN(en), .start(start), .bin(bin),
    .ready(rdy2), .busy(busy2), .bcd(bcd2), .valid(val2), .overflow(ovf2));

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && en) en_edges++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r = 0;
    int p = 1;
    for (int i = 0; i < d; i++) begin
      r |= 32'((v / p) % 10) << (4 * i);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return v >= p;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (val3) begin
      if (q3.size() == 0) chk("unexpected_valid3", 1, 0);
      else begin
        e = q3.pop_front();
        chk("bcd3", 32'(bcd3), ref_bcd(e.v, 3));
        chk("ovf3", 32'(ovf3), 32'(ref_ovf(e.v, 3)));
        chk("latency3", en_edges, e.e0 + 8);
      end
    end
    if (val2) begin
      if (q2.size() == 0) chk("unexpected_valid2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("bcd2", 32'(bcd2), ref_bcd(e.v, 2));
        chk("ovf2", 32'(ovf2), 32'(ref_ovf(e.v, 2)));
        chk("latency2", en_edges, e.e0 + 8);
      end
    end
  end

  task automatic cyc(input logic s, input logic [7:0] b, input logic e);
    start = s;
    bin = b;
    en = e;
    if (rst_n && e && s && rdy3) q3.push_back('{int'(b), en_edges + 1});
    if (rst_n && e && s && rdy2) q2.push_back('{int'(b), en_edges + 1});
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!val3 && n < 40) begin
      cyc(1'b0, 8'($urandom), 1'b1);
      n++;
    end
    if (!val3) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_bcd", 32'(bcd3), 0);
    chk("rst_valid", 32'(val3), 0);
    chk("rst_ovf", 32'(ovf3), 0);
    chk("rst_busy", 32'(busy3), 0);
    chk("rst_ready", 32'(rdy3), 1);
    cyc(1'b1, 8'd255, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("busy_255", 32'(busy3), 1);
      chk("ready_255", 32'(rdy3), 0);
      if (i < 7) cyc(1'b0, 8'($urandom), 1'b1);
    end
    cyc(1'b0, 8'd0, 1'b1);
    chk("valid_255", 32'(val3), 1);
    chk("busy_done", 32'(busy3), 0);
    cyc(1'b1, 8'd0, 1'b1);
    wait_valid();
    cyc(1'b1, 8'd9, 1'b1);
    wait_valid();
    cyc(1'b1, 8'd100, 1'b1);
    wait_valid();
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd200, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd55, 1'b1);
    wait_valid();
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd123, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'($urandom), 1'b0);
      chk("stall_busy", 32'(busy3), 1);
      chk("stall_valid", 32'(val3), 0);
    end
    wait_valid();
    cyc(1'b1, 8'd99, 1'b1);
    wait_valid();
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b1, 8'd77, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    rst_n = 1'b0;
    q3.delete();
    q2.delete();
    cyc(1'b1, 8'd0, 1'b1);
    rst_n = 1'b1;
    chk("abort_bcd", 32'(bcd3), 0);
    chk("abort_ready", 32'(rdy3), 1);
    chk("abort_valid", 32'(val3), 0);
    cyc(1'b1, 8'd77, 1'b1);
    wait_valid();
    for (int i = 0; i < 2500; i++)
      cyc(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 9) != 0));
    for (int i = 0; i < 100 && (q3.size() != 0 || q2.size() != 0); i++)
      cyc(1'b0, 8'($urandom), 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("drain3", q3.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
